// File: rtl/decoder_sync_ctrl_pkg.sv
// rtl/decoder_sync_ctrl_pkg.sv - shared types and comma helper for the link-sync controller
package decoder_sync_pkg;

    typedef enum logic [2:0] {
        HUNT,
        SLIP,
        WAIT,
        CHECK,
        SYNC
    } sync_state_t;

    localparam logic [7:0] K28_5 = 8'hBC;

    function automatic logic is_comma(input logic k, input logic [7:0] data);
        return k && (data == K28_5);
    endfunction

endpackage

// File: rtl/decoder_sync_ctrl_if.sv
// rtl/decoder_sync_ctrl_if.sv - decoder-side, forwarded-word and statistics signals of the sync controller
interface decoder_sync_ctrl_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 sync_en;
    logic                 dec_valid;
    logic [7:0]           dec_data;
    logic                 dec_k;
    logic                 dec_code_err;
    logic                 dec_disp_err;
    logic                 bitslip;
    logic                 sync_ok;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_k;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 err_clr;

    modport master (
        output sync_en, dec_valid, dec_data, dec_k, dec_code_err, dec_disp_err, err_clr,
        input  bitslip, sync_ok, rx_valid, rx_data, rx_k, err_cnt
    );

    modport slave (
        input  sync_en, dec_valid, dec_data, dec_k, dec_code_err, dec_disp_err, err_clr,
        output bitslip, sync_ok, rx_valid, rx_data, rx_k, err_cnt
    );
endinterface

// File: rtl/decoder_sync_ctrl_sat_counter.sv
// rtl/decoder_sync_ctrl_sat_counter.sv - saturating up-counter with synchronous clear priority
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/decoder_sync_ctrl.sv
// rtl/decoder_sync_ctrl.sv - comma hunt, bitslip and error-credit link sync behind the 8b/10b decoder
// Build option DECODER_SYNC_IDLE_DROP_EN: commas received in SYNC are consumed instead of forwarded.
module decoder_sync_ctrl
    import decoder_sync_pkg::*;
#(
    parameter int COMMA_LOCK   = 3,
    parameter int ERR_LOSS     = 4,
    parameter int GOOD_CREDIT  = 4,
    parameter int SLIP_TIMEOUT = 20,
    parameter int SLIP_WAIT    = 4,
    parameter int ERR_CNT_W    = 16
) (
    input logic               clk,
    input logic               rst,
    decoder_sync_ctrl_if.slave bus
);
    localparam int WORD_W  = $clog2(SLIP_TIMEOUT + 1);
    localparam int COMMA_W = $clog2(COMMA_LOCK + 1);
    localparam int BAD_W   = $clog2(ERR_LOSS + 1);
    localparam int GOOD_W  = $clog2(GOOD_CREDIT + 1);
    localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

    localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(SLIP_TIMEOUT - 1);
    localparam logic [COMMA_W-1:0] COMMA_LAST = COMMA_W'(COMMA_LOCK - 1);
    localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(ERR_LOSS - 1);
    localparam logic [GOOD_W-1:0]  GOOD_LAST  = GOOD_W'(GOOD_CREDIT - 1);
    localparam logic [GOOD_W-1:0]  GOOD_MAX   = GOOD_W'(GOOD_CREDIT);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);

    sync_state_t        r_state, w_state_nx;
    logic [WORD_W-1:0]  r_word_cnt, w_word_cnt_nx;
    logic [COMMA_W-1:0] r_comma_cnt, w_comma_cnt_nx;
    logic [BAD_W-1:0]   r_bad_cnt, w_bad_cnt_nx;
    logic [GOOD_W-1:0]  r_good_cnt, w_good_cnt_nx;
    logic [WAIT_W-1:0]  r_wait_cnt, w_wait_cnt_nx;

    logic       r_sync_ok;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       r_rx_k;

    logic w_err, w_bad, w_good, w_comma, w_fwd, w_err_inc;

    assign w_err   = bus.dec_code_err | bus.dec_disp_err;
    assign w_bad   = bus.dec_valid & w_err;
    assign w_good  = bus.dec_valid & ~w_err;
    assign w_comma = w_good & is_comma(bus.dec_k, bus.dec_data);

    always_comb begin
        w_state_nx     = r_state;
        w_word_cnt_nx  = r_word_cnt;
        w_comma_cnt_nx = r_comma_cnt;
        w_bad_cnt_nx   = r_bad_cnt;
        w_good_cnt_nx  = r_good_cnt;
        w_wait_cnt_nx  = r_wait_cnt;

        case (r_state)
            HUNT: begin
                if (w_comma) begin
                    w_word_cnt_nx = '0;
                    if (COMMA_LOCK == 1) begin
                        w_state_nx    = SYNC;
                        w_bad_cnt_nx  = '0;
                        w_good_cnt_nx = '0;
                    end else begin
                        w_state_nx     = CHECK;
                        w_comma_cnt_nx = COMMA_W'(1);
                    end
                end else if (bus.dec_valid) begin
                    if (r_word_cnt == WORD_LAST) begin
                        w_state_nx    = SLIP;
                        w_word_cnt_nx = '0;
                    end else begin
                        w_word_cnt_nx = r_word_cnt + WORD_W'(1);
                    end
                end
            end
            SLIP: begin
                w_state_nx    = WAIT;
                w_wait_cnt_nx = '0;
            end
            // Input is blanked while the deserializer settles after the shift.
            WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nx    = HUNT;
                    w_wait_cnt_nx = '0;
                    w_word_cnt_nx = '0;
                end else begin
                    w_wait_cnt_nx = r_wait_cnt + WAIT_W'(1);
                end
            end
            CHECK: begin
                if (w_comma) begin
                    if (r_comma_cnt == COMMA_LAST) begin
                        w_state_nx     = SYNC;
                        w_comma_cnt_nx = '0;
                        w_bad_cnt_nx   = '0;
                        w_good_cnt_nx  = '0;
                    end else begin
                        w_comma_cnt_nx = r_comma_cnt + COMMA_W'(1);
                    end
                end else if (w_bad) begin
                    w_state_nx     = HUNT;
                    w_comma_cnt_nx = '0;
                    w_word_cnt_nx  = '0;
                end
            end
            SYNC: begin
                if (w_bad) begin
                    if (r_bad_cnt == BAD_LAST) begin
                        w_state_nx    = HUNT;
                        w_word_cnt_nx = '0;
                        w_bad_cnt_nx  = '0;
                        w_good_cnt_nx = '0;
                    end else begin
                        w_bad_cnt_nx  = r_bad_cnt + BAD_W'(1);
                        w_good_cnt_nx = '0;
                    end
                end else if (w_good) begin
                    // A run of good words buys back one counted error.
                    if (r_bad_cnt != '0) begin
                        if (r_good_cnt == GOOD_LAST) begin
                            w_bad_cnt_nx  = r_bad_cnt - BAD_W'(1);
                            w_good_cnt_nx = '0;
                        end else begin
                            w_good_cnt_nx = r_good_cnt + GOOD_W'(1);
                        end
                    end else if (r_good_cnt != GOOD_MAX) begin
                        w_good_cnt_nx = r_good_cnt + GOOD_W'(1);
                    end
                end
            end
            default: w_state_nx = HUNT;
        endcase

        if (!bus.sync_en) begin
            w_state_nx     = HUNT;
            w_word_cnt_nx  = '0;
            w_comma_cnt_nx = '0;
            w_bad_cnt_nx   = '0;
            w_good_cnt_nx  = '0;
            w_wait_cnt_nx  = '0;
        end
    end

`ifdef DECODER_SYNC_IDLE_DROP_EN
    assign w_fwd = bus.dec_valid & (r_state == SYNC) & ~w_bad & ~w_comma;
`else
    assign w_fwd = bus.dec_valid & (r_state == SYNC) & ~w_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_word_cnt  <= '0;
            r_comma_cnt <= '0;
            r_bad_cnt   <= '0;
            r_good_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_sync_ok   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
            r_rx_k      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_word_cnt  <= w_word_cnt_nx;
            r_comma_cnt <= w_comma_cnt_nx;
            r_bad_cnt   <= w_bad_cnt_nx;
            r_good_cnt  <= w_good_cnt_nx;
            r_wait_cnt  <= w_wait_cnt_nx;
            r_sync_ok   <= (w_state_nx == SYNC);
            r_rx_valid  <= w_fwd;
            if (bus.dec_valid) begin
                r_rx_data <= bus.dec_data;
                r_rx_k    <= bus.dec_k;
            end
        end
    end

    assign w_err_inc = w_bad & ((r_state == HUNT) | (r_state == CHECK) | (r_state == SYNC));

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_err_inc),
        .i_clr (bus.err_clr),
        .o_q   (bus.err_cnt)
    );

    // Gating by sync_en lets a late disable cancel a pulse during the SLIP cycle.
    assign bus.bitslip  = (r_state == SLIP) & bus.sync_en;
    assign bus.sync_ok  = r_sync_ok;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_k     = r_rx_k;
endmodule

// File: tb/tb_decoder_sync_ctrl.sv
// tb/tb_decoder_sync_ctrl.sv - directed vectors for the link-sync controller
module tb_decoder_sync_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_err;

    always #5 clk = ~clk;

    decoder_sync_ctrl_if #(.ERR_CNT_W(16)) bus ();

    decoder_sync_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic v, input logic k, input logic [7:0] d,
                       input logic ce, input logic de);
        bus.dec_valid    = v;
        bus.dec_k        = k;
        bus.dec_data     = d;
        bus.dec_code_err = ce;
        bus.dec_disp_err = de;
        @(posedge clk);
        #1;
    endtask

    task automatic put_d(input logic [7:0] d);
        put(1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic put_comma();
        put(1'b1, 1'b1, 8'hBC, 1'b0, 1'b0);
    endtask

    task automatic put_bad(input logic ce, input logic de);
        put(1'b1, 1'b0, 8'h3C, ce, de);
    endtask

    task automatic lock3();
        put_comma();
        put_comma();
        put_comma();
    endtask

    initial begin
        rst          = 1'b1;
        bus.sync_en  = 1'b1;
        bus.err_clr  = 1'b0;
        put(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        put(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_vec("rst_sync_ok", bus.sync_ok, 0);
        check_vec("rst_bitslip", bus.bitslip, 0);
        check_vec("rst_rx_valid", bus.rx_valid, 0);
        check_vec("rst_rx_data", bus.rx_data, 0);
        check_vec("rst_rx_k", bus.rx_k, 0);
        check_vec("rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;

        // Slip timeout: 20 D words, then SLIP, then 4 blanked cycles
        for (int i = 0; i < 19; i++) begin
            put_d(8'(i + 1));
            check_vec("hunt_no_slip", bus.bitslip, 0);
        end
        put_d(8'h14);
        check_vec("slip_pulse", bus.bitslip, 1);
        put_bad(1'b1, 1'b0);
        check_vec("slip_once", bus.bitslip, 0);
        for (int i = 0; i < 4; i++) begin
            put_bad(1'b1, 1'b0);
            check_vec("wait_no_slip", bus.bitslip, 0);
        end
        check_vec("wait_no_err", bus.err_cnt, 0);
        put_bad(1'b1, 1'b0);
        exp_err = 1;
        check_vec("hunt_err", bus.err_cnt, 32'(exp_err));

        // Comma lock with interleaved data
        put_comma();
        put_d(8'h11);
        put_comma();
        put_d(8'h22);
        check_vec("check_not_sync", bus.sync_ok, 0);
        put_comma();
        check_vec("sync_rise", bus.sync_ok, 1);
        check_vec("lock_word_not_fwd", bus.rx_valid, 0);
        put_d(8'h55);
        check_vec("fwd_valid", bus.rx_valid, 1);
        check_vec("fwd_data", bus.rx_data, 8'h55);
        check_vec("fwd_k", bus.rx_k, 0);

        // Comma received in SYNC
        put_comma();
`ifdef DECODER_SYNC_IDLE_DROP_EN
        check_vec("comma_dropped", bus.rx_valid, 0);
`else
        check_vec("comma_fwd_valid", bus.rx_valid, 1);
        check_vec("comma_fwd_k", bus.rx_k, 1);
        check_vec("comma_fwd_data", bus.rx_data, 8'hBC);
`endif

        // Error credit: bad, 4 good, bad, 4 good, bad x3 keeps sync
        put_bad(1'b1, 1'b0);
        check_vec("bad_not_fwd", bus.rx_valid, 0);
        for (int i = 0; i < 4; i++) put_d(8'hA0);
        put_bad(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) put_d(8'hA1);
        put_bad(1'b1, 1'b0);
        put_bad(1'b1, 1'b0);
        put_bad(1'b1, 1'b0);
        exp_err = exp_err + 5;
        check_vec("credit_hold_sync", bus.sync_ok, 1);
        check_vec("credit_err_cnt", bus.err_cnt, 32'(exp_err));
        put_bad(1'b1, 1'b0);
        exp_err = exp_err + 1;
        check_vec("credit_loss", bus.sync_ok, 0);
        check_vec("credit_loss_err", bus.err_cnt, 32'(exp_err));

        // err_clr beats a simultaneous increment
        bus.err_clr = 1'b1;
        put_bad(1'b1, 1'b0);
        bus.err_clr = 1'b0;
        exp_err = 0;
        check_vec("clr_priority", bus.err_cnt, 32'(exp_err));

        // Loss after 4 bad words interleaved with 2 good
        lock3();
        check_vec("relock", bus.sync_ok, 1);
        put_bad(1'b1, 1'b0);
        put_d(8'h01);
        put_bad(1'b0, 1'b1);
        put_d(8'h02);
        put_bad(1'b1, 1'b1);
        check_vec("interleave_hold", bus.sync_ok, 1);
        put_bad(1'b1, 1'b0);
        exp_err = 4;
        check_vec("interleave_loss", bus.sync_ok, 0);
        check_vec("interleave_err", bus.err_cnt, 32'(exp_err));

        // sync_en low in SYNC, then during SLIP
        lock3();
        check_vec("relock2", bus.sync_ok, 1);
        bus.sync_en = 1'b0;
        put_d(8'h33);
        check_vec("en_off_sync", bus.sync_ok, 0);
        bus.sync_en = 1'b1;
        for (int i = 0; i < 19; i++) put_d(8'h44);
        put_d(8'h45);
        check_vec("slip_pulse2", bus.bitslip, 1);
        bus.sync_en = 1'b0;
        #1;
        check_vec("slip_suppressed", bus.bitslip, 0);
        put(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_vec("en_off_slip_sync", bus.sync_ok, 0);
        check_vec("en_off_slip_bs", bus.bitslip, 0);
        bus.sync_en = 1'b1;
        put_bad(1'b1, 1'b0);
        exp_err = exp_err + 1;
        check_vec("back_in_hunt", bus.err_cnt, 32'(exp_err));
        check_vec("no_late_slip", bus.bitslip, 0);

        // Reset mid-operation
        lock3();
        put_d(8'h77);
        check_vec("pre_rst_valid", bus.rx_valid, 1);
        rst = 1'b1;
        put_d(8'h78);
        check_vec("mid_rst_sync", bus.sync_ok, 0);
        check_vec("mid_rst_valid", bus.rx_valid, 0);
        check_vec("mid_rst_data", bus.rx_data, 0);
        check_vec("mid_rst_err", bus.err_cnt, 0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
